dca_lsu_rdata_unpacker: RTL and testbench

- Registered, flow-controlled successor to the DCA matrix LSU read-data element extender.
- Takes packed memory read beats and emits one sign- or zero-extended element row per cycle.
- A beat may carry several rows when elements are narrow (1..16 bit).
- Sits between the AXI read-data buffer and the matrix LSU row sink; runs one load transaction at a time, with row counting and early/late beat handling.

---
 rtl/dca_lsu_unpack_pkg.sv | 35 +++
 rtl/dca_lsu_element_extender.sv | 39 +++
 rtl/dca_lsu_rdata_unpacker.sv | 209 ++++++++++++++++++++
 tb/tb_dca_lsu_rdata_unpacker.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dca_lsu_unpack_pkg.sv
// Shared types and helpers for the DCA matrix LSU read-data unpacker.
// Element width is encoded as lsa_p3 = log2(element bits); codes above
// 5 behave like 32-bit elements.
package dca_lsu_unpack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [2:0] LSA_P3_1BIT  = 3'd0;
    localparam logic [2:0] LSA_P3_2BIT  = 3'd1;
    localparam logic [2:0] LSA_P3_4BIT  = 3'd2;
    localparam logic [2:0] LSA_P3_8BIT  = 3'd3;
    localparam logic [2:0] LSA_P3_16BIT = 3'd4;
    localparam logic [2:0] LSA_P3_32BIT = 3'd5;
    localparam logic [2:0] LSA_P3_MAX   = LSA_P3_32BIT;

    // Fold the unused codes 6 and 7 onto the 32-bit encoding.
    function automatic logic [2:0] clamp_lsa_p3(input logic [2:0] lsa_p3);
        return (lsa_p3 > LSA_P3_MAX) ? LSA_P3_MAX : lsa_p3;
    endfunction

    // Element width in bits (1..32).
    function automatic logic [5:0] elem_bits(input logic [2:0] lsa_p3);
        return 6'd1 << clamp_lsa_p3(lsa_p3);
    endfunction

    // Rows carried by one 32-bit-per-column beat (32..1).
    function automatic logic [5:0] rows_per_beat(input logic [2:0] lsa_p3);
        return 6'd32 >> clamp_lsa_p3(lsa_p3);
    endfunction

endpackage

// File: rtl/dca_lsu_element_extender.sv
// Combinational element extender: takes one sub-row (already shifted down to
// bit 0) and returns MATRIX_NUM_COL elements, each sign- or zero-extended
// from the element width selected by lsa_p3 to BW_LSU_ELEMENT bits.
module dca_lsu_element_extender
    import dca_lsu_unpack_pkg::*;
#(
    parameter int MATRIX_NUM_COL = 4,
    parameter int BW_LSU_ELEMENT = 32
) (
    input  logic [32*MATRIX_NUM_COL-1:0]             sub_row,
    input  logic [2:0]                               lsa_p3,
    input  logic                                     is_signed,
    output logic [BW_LSU_ELEMENT*MATRIX_NUM_COL-1:0] elements
);

    logic [5:0]  w;
    logic [31:0] mask;
    logic [31:0] top_bit;
    logic        do_sext;

    assign w       = elem_bits(lsa_p3);
    // For w=32 the shift overflows to zero and the subtraction yields all ones.
    assign mask    = (32'd1 << w) - 32'd1;
    assign top_bit = 32'd1 << (w - 6'd1);
    // A 1-bit element has no room for a sign bit, so it is always zero-extended.
    assign do_sext = is_signed && (clamp_lsa_p3(lsa_p3) != LSA_P3_1BIT);

    for (genvar i = 0; i < MATRIX_NUM_COL; i++) begin : g_elem
        logic [31:0] field;
        logic        sign;

        assign field = 32'(sub_row >> (i * int'(w))) & mask;
        assign sign  = |(field & top_bit);
        assign elements[i*BW_LSU_ELEMENT +: BW_LSU_ELEMENT] =
            (do_sext && sign) ? (BW_LSU_ELEMENT'(field) | ~BW_LSU_ELEMENT'(mask))
                              : BW_LSU_ELEMENT'(field);
    end

endmodule

// File: rtl/dca_lsu_rdata_unpacker.sv
// Registered, flow-controlled read-data unpacker. Accepts packed memory beats,
// emits one extended element row per cycle, holds the remaining sub-rows of a
// beat in a one-beat buffer, counts rows, flags short bursts and drains any
// surplus beats of the burst once the transaction has all its rows.
module dca_lsu_rdata_unpacker
    import dca_lsu_unpack_pkg::*;
#(
    parameter int MATRIX_NUM_COL = 4,
    parameter int BW_LSU_ELEMENT = 32,
    parameter int BW_NUM_ROW_M1  = 16,
    parameter int BW_TXN_INFO    = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     cfg_valid,
    output logic                                     cfg_ready,
    input  logic [2:0]                               cfg_lsa_p3,
    input  logic                                     cfg_is_signed,
    input  logic [BW_NUM_ROW_M1-1:0]                 cfg_num_row_m1,
    input  logic [BW_TXN_INFO-1:0]                   cfg_txn_info,
    input  logic                                     beat_valid,
    output logic                                     beat_ready,
    input  logic [32*MATRIX_NUM_COL-1:0]             beat_data,
    input  logic                                     beat_last,
    output logic                                     row_valid,
    input  logic                                     row_ready,
    output logic [BW_LSU_ELEMENT*MATRIX_NUM_COL-1:0] row_data,
    output logic                                     row_last,
    output logic [BW_TXN_INFO-1:0]                   row_txn_info,
    output logic                                     err_short
);

    localparam int BW_BEAT = 32 * MATRIX_NUM_COL;
    localparam int BW_ROW  = BW_LSU_ELEMENT * MATRIX_NUM_COL;
    localparam int BW_LEFT = BW_NUM_ROW_M1 + 1;

    state_t                   state, next_state;

    logic [2:0]               lsa_q;
    logic                     signed_q;
    logic [BW_NUM_ROW_M1-1:0] num_row_m1_q;
    logic [BW_TXN_INFO-1:0]   txn_q;
    logic [BW_NUM_ROW_M1-1:0] row_cnt;

    logic [BW_BEAT-1:0]       beat_buf;
    logic [5:0]               pend_cnt;   // sub-rows still held in beat_buf
    logic [4:0]               sub_idx;    // index of the next buffered sub-row
    logic                     term_q;     // buffered beat finishes the transaction
    logic                     last_q;     // buffered beat carried beat_last
    logic                     done_q;     // last row loaded, waiting for its handshake

    logic                     out_free;
    logic [BW_LEFT-1:0]       rows_left;
    logic [5:0]               rpb;
    logic [5:0]               n_take;
    logic                     beat_term;
    logic                     beat_short;

    logic                     load_bypass;
    logic                     load_buf;
    logic                     end_load;
    logic                     end_to_idle;
    logic                     done_hs;

    logic [BW_BEAT-1:0]       sel_beat;
    logic [4:0]               sel_idx;
    logic [31:0]              shamt;
    logic [BW_BEAT-1:0]       sub_row;
    logic [BW_ROW-1:0]        ext_row;

    assign out_free   = !row_valid || row_ready;
    assign rows_left  = {1'b0, num_row_m1_q} - {1'b0, row_cnt} + BW_LEFT'(1);
    assign rpb        = rows_per_beat(lsa_q);
    assign n_take     = (rows_left < BW_LEFT'(rpb)) ? rows_left[5:0] : rpb;
    assign beat_term  = beat_last || (rows_left <= BW_LEFT'(rpb));
    assign beat_short = beat_last && (rows_left > BW_LEFT'(rpb));

    // The output register loads either a buffered sub-row or sub-row 0 of
    // the incoming beat; both come through the same extractor.
    assign sel_beat = load_buf ? beat_buf : beat_data;
    assign sel_idx  = load_buf ? sub_idx : 5'd0;
    assign shamt    = 32'(sel_idx) * 32'(MATRIX_NUM_COL) * 32'(elem_bits(lsa_q));
    assign sub_row  = sel_beat >> shamt;

    dca_lsu_element_extender #(
        .MATRIX_NUM_COL (MATRIX_NUM_COL),
        .BW_LSU_ELEMENT (BW_LSU_ELEMENT)
    ) u_extender (
        .sub_row   (sub_row),
        .lsa_p3    (lsa_q),
        .is_signed (signed_q),
        .elements  (ext_row)
    );

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next-state, handshake and load-source decode
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        next_state  = state;
        cfg_ready   = 1'b0;
        beat_ready  = 1'b0;
        load_bypass = 1'b0;
        load_buf    = 1'b0;
        end_load    = 1'b0;
        end_to_idle = 1'b0;
        done_hs     = 1'b0;
        case (state)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) next_state = ST_RUN;
            end
            ST_RUN: begin
                if (done_q) begin
                    done_hs = row_valid && row_ready;
                    if (done_hs) next_state = ST_IDLE;
                end else if (out_free) begin
                    if (pend_cnt != 6'd0) begin
                        load_buf    = 1'b1;
                        end_load    = (pend_cnt == 6'd1) && term_q;
                        end_to_idle = last_q;
                    end else begin
                        beat_ready  = 1'b1;
                        load_bypass = beat_valid;
                        end_load    = beat_valid && (n_take == 6'd1) && beat_term;
                        end_to_idle = beat_last;
                    end
                    // Burst not finished yet: swallow the rest of it.
                    if (end_load && !end_to_idle) next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                beat_ready = 1'b1;
                if (beat_valid && beat_last) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Config latch, output register, row counter and sub-row bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            lsa_q        <= LSA_P3_1BIT;
            signed_q     <= 1'b0;
            num_row_m1_q <= '0;
            txn_q        <= '0;
            row_cnt      <= '0;
            pend_cnt     <= 6'd0;
            sub_idx      <= 5'd0;
            term_q       <= 1'b0;
            last_q       <= 1'b0;
            done_q       <= 1'b0;
            row_valid    <= 1'b0;
            row_last     <= 1'b0;
            row_data     <= '0;
            row_txn_info <= '0;
            err_short    <= 1'b0;
        end else begin
            err_short <= 1'b0;

            if (cfg_ready && cfg_valid) begin
                lsa_q        <= cfg_lsa_p3;
                signed_q     <= cfg_is_signed;
                num_row_m1_q <= cfg_num_row_m1;
                txn_q        <= cfg_txn_info;
                row_cnt      <= '0;
                done_q       <= 1'b0;
            end

            if (load_bypass || load_buf) begin
                row_valid    <= 1'b1;
                row_data     <= ext_row;
                row_last     <= end_load;
                row_txn_info <= txn_q;
                row_cnt      <= row_cnt + BW_NUM_ROW_M1'(1);
            end else if (out_free) begin
                row_valid <= 1'b0;
                row_last  <= 1'b0;
            end

            // Only min(R, rows_left) sub-rows are kept; the rest are never loaded.
            if (load_bypass) begin
                pend_cnt  <= n_take - 6'd1;
                sub_idx   <= 5'd1;
                term_q    <= beat_term;
                last_q    <= beat_last;
                err_short <= beat_short;
            end else if (load_buf) begin
                pend_cnt <= pend_cnt - 6'd1;
                sub_idx  <= sub_idx + 5'd1;
            end

            if (end_load && end_to_idle) done_q <= 1'b1;
            else if (done_hs)            done_q <= 1'b0;
        end
    end

    // Capture the accepted beat for its remaining sub-rows
    always_ff @(posedge clk) begin
        // NOTE: the beat buffer has no reset; pend_cnt=0 after reset makes its contents unreachable.
        if (load_bypass) beat_buf <= beat_data;
    end

endmodule

// File: tb/tb_dca_lsu_rdata_unpacker.sv
// Directed bench for dca_lsu_rdata_unpacker: per transaction a reference model
// fills a scoreboard of expected rows, which is popped on each row handshake.
module tb_dca_lsu_rdata_unpacker;

    typedef struct {
        logic [127:0] data;
        logic         last;
        logic [7:0]   txn;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [2:0]   cfg_lsa_p3;
    logic         cfg_is_signed;
    logic [15:0]  cfg_num_row_m1;
    logic [7:0]   cfg_txn_info;
    logic         beat_valid;
    logic         beat_ready;
    logic [127:0] beat_data;
    logic         beat_last;
    logic         row_valid;
    logic         row_ready;
    logic [127:0] row_data;
    logic         row_last;
    logic [7:0]   row_txn_info;
    logic         err_short;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;

    logic [127:0] tb_beats[$];
    bit           tb_lasts[$];

    dca_lsu_rdata_unpacker dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_lsa_p3     (cfg_lsa_p3),
        .cfg_is_signed  (cfg_is_signed),
        .cfg_num_row_m1 (cfg_num_row_m1),
        .cfg_txn_info   (cfg_txn_info),
        .beat_valid     (beat_valid),
        .beat_ready     (beat_ready),
        .beat_data      (beat_data),
        .beat_last      (beat_last),
        .row_valid      (row_valid),
        .row_ready      (row_ready),
        .row_data       (row_data),
        .row_last       (row_last),
        .row_txn_info   (row_txn_info),
        .err_short      (err_short)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference row: element i of sub-row k, extended from w bits to 32.
    function automatic logic [127:0] model_row(input logic [127:0] beat, input int w,
                                               input int k, input logic sgn);
        logic [127:0] r;
        logic [31:0]  e;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            e = 32'(beat >> ((k * 4 + i) * w));
            if (w < 32) begin
                if (sgn && w > 1) e = 32'($signed(e << (32 - w)) >>> (32 - w));
                else              e = (e << (32 - w)) >> (32 - w);
            end
            r[i*32 +: 32] = e;
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic run_txn(input logic [2:0] lsa, input logic sgn, input logic [15:0] nm1,
                           input logic [7:0] tag, input bit rnd_ready, input bit cfg_noise,
                           input string name, output int t_fire, output int t_first,
                           output int t_last, output logic [127:0] first_row);
        exp_t exp_q[$];
        exp_t e;
        int   w, r, left, take, nb, bi, exp_short, got_short, budget;
        bit   term, done;

        w    = 1 << ((lsa > 3'd5) ? 5 : int'(lsa));
        r    = 32 / w;
        left = int'(nm1) + 1;
        done = 0;
        exp_short = 0;
        nb   = tb_beats.size();
        for (int b = 0; b < nb && !done; b++) begin
            take = (left < r) ? left : r;
            term = tb_lasts[b] || (left <= r);
            if (tb_lasts[b] && left > r) exp_short++;
            for (int k = 0; k < take; k++) begin
                e.data = model_row(tb_beats[b], w, k, sgn);
                e.last = (k == take - 1) && term;
                e.txn  = tag;
                exp_q.push_back(e);
            end
            left -= take;
            done  = term;
        end

        @(posedge clk); #1;
        cfg_valid      = 1'b1;
        cfg_lsa_p3     = lsa;
        cfg_is_signed  = sgn;
        cfg_num_row_m1 = nm1;
        cfg_txn_info   = tag;
        @(negedge clk);
        check({name, " cfg_ready idle"}, cfg_ready, 1'b1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        if (cfg_noise) begin
            cfg_lsa_p3     = 3'd0;
            cfg_num_row_m1 = 16'd0;
            cfg_txn_info   = 8'hEE;
        end

        bi = 0; got_short = 0; t_fire = -1; t_first = -1; t_last = -1; first_row = '0;
        for (budget = 0; budget < 2000; budget++) begin
            beat_valid = (bi < nb);
            beat_data  = (bi < nb) ? tb_beats[bi] : '0;
            beat_last  = (bi < nb) ? tb_lasts[bi] : 1'b0;
            row_ready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            cfg_valid  = cfg_noise && (bi < nb);
            @(negedge clk);
            if (err_short) got_short++;
            if (bi < nb) check({name, " cfg_ready busy"}, cfg_ready, 1'b0);
            if (row_valid) begin
                if (exp_q.size() == 0) begin
                    check({name, " unexpected row_valid"}, row_valid, 1'b0);
                end else begin
                    if (t_first < 0) begin
                        t_first   = cyc;
                        first_row = row_data;
                    end
                    check({name, " row_data"}, row_data, exp_q[0].data);
                    check({name, " row_last"}, row_last, exp_q[0].last);
                    check({name, " row_txn_info"}, row_txn_info, exp_q[0].txn);
                    if (row_ready) begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) t_last = cyc;
                    end
                end
            end
            if (beat_valid && beat_ready) begin
                if (t_fire < 0) t_fire = cyc;
                bi++;
            end
            if (bi == nb && exp_q.size() == 0 && cfg_ready) break;
            @(posedge clk); #1;
        end
        cfg_valid = 1'b0;
        check({name, " rows outstanding"}, exp_q.size(), 0);
        check({name, " beats consumed"}, bi, nb);
        check({name, " back to idle"}, cfg_ready, 1'b1);
        check({name, " err_short pulses"}, got_short, exp_short);
    endtask

    initial begin
        int           tf, t0, tl;
        logic [127:0] fr;
        logic [127:0] bd;

        rst = 1'b1; cfg_valid = 1'b0; cfg_lsa_p3 = 3'd0; cfg_is_signed = 1'b0;
        cfg_num_row_m1 = 16'd0; cfg_txn_info = 8'd0; beat_valid = 1'b0;
        beat_data = '0; beat_last = 1'b0; row_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset row_valid", row_valid, 1'b0);
        check("reset cfg_ready", cfg_ready, 1'b1);
        check("reset beat_ready", beat_ready, 1'b0);
        check("reset row_data", row_data, 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 32-bit signed, 3 rows from 3 beats: pass-through, 1-cycle latency, no bubbles
        tb_beats.delete(); tb_lasts.delete();
        for (int b = 0; b < 3; b++) begin
            bd = rand128();
            bd[31:0] = 32'h8000_0001;
            tb_beats.push_back(bd);
            tb_lasts.push_back(b == 2);
        end
        run_txn(3'd5, 1'b1, 16'd2, 8'h11, 1'b0, 1'b0, "t1_w32", tf, t0, tl, fr);
        check("t1 element0", fr[31:0], 32'h8000_0001);
        check("t1 latency", t0, tf + 1);
        check("t1 last row time", tl, tf + 3);

        // 8-bit signed, 6 rows over 2 beats, last 2 sub-rows dropped
        tb_beats.delete(); tb_lasts.delete();
        for (int b = 0; b < 2; b++) begin
            bd = rand128();
            bd[7:0] = 8'hFF;
            tb_beats.push_back(bd);
            tb_lasts.push_back(b == 1);
        end
        run_txn(3'd3, 1'b1, 16'd5, 8'h22, 1'b0, 1'b0, "t2_w8s", tf, t0, tl, fr);
        check("t2 element0", fr[31:0], 32'hFFFF_FFFF);
        check("t2 back-to-back", tl - t0, 5);

        // Same beats, unsigned
        run_txn(3'd3, 1'b0, 16'd5, 8'h33, 1'b0, 1'b0, "t3_w8u", tf, t0, tl, fr);
        check("t3 element0", fr[31:0], 32'h0000_00FF);

        // 1-bit signed: never sign-extended
        tb_beats.delete(); tb_lasts.delete();
        bd = rand128();
        bd[3:0] = 4'hF;
        tb_beats.push_back(bd);
        tb_lasts.push_back(1'b1);
        run_txn(3'd0, 1'b1, 16'd0, 8'h44, 1'b0, 1'b0, "t4_w1", tf, t0, tl, fr);
        check("t4 element0", fr[31:0], 32'h0000_0001);

        // Single row out of a 3-beat burst: beats 2 and 3 drained
        tb_beats.delete(); tb_lasts.delete();
        for (int b = 0; b < 3; b++) begin
            tb_beats.push_back(rand128());
            tb_lasts.push_back(b == 2);
        end
        run_txn(3'd5, 1'b0, 16'd0, 8'h55, 1'b0, 1'b0, "t5_drain", tf, t0, tl, fr);

        // Short burst: 8 rows wanted, one 16-bit beat gives 2
        tb_beats.delete(); tb_lasts.delete();
        tb_beats.push_back(rand128());
        tb_lasts.push_back(1'b1);
        run_txn(3'd4, 1'b1, 16'd7, 8'h66, 1'b0, 1'b0, "t6_short", tf, t0, tl, fr);

        // 4-bit signed, random backpressure, cfg_valid noise while busy
        tb_beats.delete(); tb_lasts.delete();
        for (int b = 0; b < 3; b++) begin
            tb_beats.push_back(rand128());
            tb_lasts.push_back(b == 2);
        end
        run_txn(3'd2, 1'b1, 16'd19, 8'h77, 1'b1, 1'b1, "t7_stall", tf, t0, tl, fr);

        // Reset in the middle of a transaction with rows pending
        @(posedge clk); #1;
        cfg_valid = 1'b1; cfg_lsa_p3 = 3'd3; cfg_is_signed = 1'b1;
        cfg_num_row_m1 = 16'd15; cfg_txn_info = 8'h88;
        @(posedge clk); #1;
        cfg_valid  = 1'b0;
        beat_valid = 1'b1; beat_data = rand128(); beat_last = 1'b0;
        row_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        beat_valid = 1'b0;
        row_ready  = 1'b1;
        @(negedge clk);
        check("rst mid row_valid", row_valid, 1'b0);
        check("rst mid row_last", row_last, 1'b0);
        check("rst mid err_short", err_short, 1'b0);
        check("rst mid beat_ready", beat_ready, 1'b0);
        check("rst mid cfg_ready", cfg_ready, 1'b1);
        check("rst mid row_data", row_data, 128'd0);
        check("rst mid row_txn_info", row_txn_info, 8'd0);

        // Recovery with lsa_p3=6, which behaves as 32-bit elements
        tb_beats.delete(); tb_lasts.delete();
        for (int b = 0; b < 2; b++) begin
            tb_beats.push_back(rand128());
            tb_lasts.push_back(b == 1);
        end
        run_txn(3'd6, 1'b0, 16'd1, 8'h99, 1'b0, 1'b0, "t8_recover", tf, t0, tl, fr);
        check("t8 element0", fr[31:0], tb_beats[0][31:0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
